alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, datapath width; SHALL equal the ALU width (16).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: req0/req1  input  1 each  transaction request from requester 0/1.
REQ-005 Ports: op0/op1  input  5 each  ALU opcode for the transaction.
REQ-006 Ports: a0/a1, b0/b1  input  DATA_W each  first operand (accumulator load), second operand.
REQ-007 Ports: gnt0/gnt1  output  1 each  grant, registered, high for the whole transaction.
REQ-008 Ports: done0/done1  output  1 each  one-cycle pulse; result valid in that cycle.
REQ-009 Port: result  output  DATA_W  accumulator value captured at end of transaction.
REQ-010 Port: result_flag  output  1  ALU flag captured at end of transaction.
REQ-011 Ports to ALU: alu_opcode  output  5; alu_operand  output  DATA_W; alu_read, alu_write, alu_writeu  output  1 each; alu_accout  input  DATA_W; alu_flag  input  1.

Function
REQ-012 States: IDLE, LOAD, EXEC, READ, DONE; all ALU-side outputs SHALL be registered, decoded from state.
REQ-013 IDLE: alu_opcode=NOP (0), alu_read=alu_write=alu_writeu=0; req0/req1 sampled each edge.
REQ-014 Grant edge: IDLE->LOAD when any req high; winner's op, a, b latched internally; requester may drop req and change inputs afterwards.
REQ-015 Arbitration round-robin: priority pointer starts at requester 0, points to non-winner after every grant; lone requester always wins.
REQ-016 LOAD: alu_write=1, alu_operand=latched a, alu_opcode=NOP; next EXEC.
REQ-017 EXEC: alu_opcode=latched op, alu_operand=latched b, alu_write=0; next READ.
REQ-018 READ: alu_read=1, opcode NOP; result<=alu_accout, result_flag<=alu_flag at end of cycle; next DONE.
REQ-019 DONE: owner's doneN=1 for exactly one cycle; next IDLE unconditionally.
REQ-020 Latency: grant edge E0 -> doneN high in cycle after E3; back-to-back throughput one transaction per 5 cycles.
REQ-021 gntN high from LOAD through DONE inclusive; never both grants high.
REQ-022 alu_writeu SHALL be held 0 at all times.
REQ-023 Compare/NOTF opcodes: result = a (accumulator unchanged), result_flag = new ALU flag.
REQ-024 result/result_flag SHALL hold value until next READ; req asserted during a transaction is served no earlier than next IDLE.
REQ-025 Carry (ALU bit 16) not modified by LOAD; ADC/SBB use carry left by the previous transaction.

Reset
REQ-026 rst high at an edge: state IDLE, gnt0/gnt1=0, done0/done1=0, pointer=0, result=0, result_flag=0, ALU outputs as IDLE.
REQ-027 Reset mid-transaction SHALL abort it with no done pulse; ALU accumulator/flag contents undefined to requesters.

Configuration
REQ-028 Macro ALU_ARBITER_LOCK_EN defined: adds inputs lock0/lock1 (1 bit); if owner's lockN high in DONE, next IDLE grants only that owner (other req ignored, pointer frozen) until owner's lockN low while in IDLE, protecting multi-word ADC/SBB carry chains.
REQ-029 ALU_ARBITER_LOCK_EN undefined: no lock ports, pure round-robin per REQ-015.

Verification
REQ-030 req0, op0=ADD, a0=0x1234, b0=0x0001 -> LOAD/EXEC/READ sequence on ALU pins, done0 one cycle, result=0x1235, gnt1 never high.
REQ-031 req0 and req1 both high from reset, held -> grants alternate 0,1,0,1; done pulses 5 cycles apart.
REQ-032 op1=CE, a1=0x00AA, b1=0x00AA -> result=0x00AA, result_flag=1; repeat with b1=0x00AB -> result_flag=0.
REQ-033 (LOCK_EN) req0 lock0=1: ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000, req1 high throughout -> second result=0x0001, req1 granted only after lock0 low.
REQ-034 rst asserted in EXEC -> next cycle IDLE, gnt/done low, no done pulse; new req0 completes normally.
REQ-035 req dropped the cycle after grant, a0/b0 changed -> result uses values latched at grant edge.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter that sequences two requesters through a
//            shared accumulator ALU (LOAD a, EXEC op b, READ accumulator).
//            Optional macro ALU_ARBITER_LOCK_EN adds lock0/lock1 inputs.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [4:0]        op0,
    input  logic [4:0]        op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              result_flag,
    output logic [4:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand,
    output logic              alu_read,
    output logic              alu_write,
    output logic              alu_writeu,
    input  logic [DATA_W-1:0] alu_accout,
    input  logic              alu_flag
);

    localparam logic [4:0] C_OP_NOP = 5'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_READ = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic              r_owner;
    logic [4:0]        r_op;
    logic [DATA_W-1:0] r_b;

    logic w_hold;
    logic w_any;
    logic w_pick1;

`ifdef ALU_ARBITER_LOCK_EN
    logic r_locked;
    logic w_owner_lock;
    assign w_owner_lock = r_owner ? lock1 : lock0;
    assign w_hold       = r_locked & w_owner_lock;
`else
    assign w_hold = 1'b0;
`endif

    // While a lock is held only the previous owner may be granted.
    assign w_any   = w_hold ? (r_owner ? req1 : req0) : (req0 | req1);
    assign w_pick1 = w_hold ? r_owner : (req1 & (~req0 | r_ptr));

    // Carry is never touched by the arbiter, so writeu stays low permanently.
    assign alu_writeu = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_op        <= C_OP_NOP;
            r_b         <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            result_flag <= 1'b0;
            alu_opcode  <= C_OP_NOP;
            alu_operand <= '0;
            alu_read    <= 1'b0;
            alu_write   <= 1'b0;
`ifdef ALU_ARBITER_LOCK_EN
            r_locked    <= 1'b0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
`ifdef ALU_ARBITER_LOCK_EN
                    if (r_locked && !w_owner_lock) begin
                        r_locked <= 1'b0;
                    end
`endif
                    if (w_any) begin
                        r_state     <= S_LOAD;
                        r_owner     <= w_pick1;
                        gnt0        <= ~w_pick1;
                        gnt1        <= w_pick1;
                        r_op        <= w_pick1 ? op1 : op0;
                        r_b         <= w_pick1 ? b1 : b0;
                        alu_operand <= w_pick1 ? a1 : a0;
                        alu_write   <= 1'b1;
                        if (!w_hold) begin
                            r_ptr <= ~w_pick1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state     <= S_EXEC;
                    alu_write   <= 1'b0;
                    alu_opcode  <= r_op;
                    alu_operand <= r_b;
                end
                S_EXEC: begin
                    r_state    <= S_READ;
                    alu_opcode <= C_OP_NOP;
                    alu_read   <= 1'b1;
                end
                S_READ: begin
                    r_state     <= S_DONE;
                    alu_read    <= 1'b0;
                    result      <= alu_accout;
                    result_flag <= alu_flag;
                    done0       <= ~r_owner;
                    done1       <= r_owner;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
`ifdef ALU_ARBITER_LOCK_EN
                    r_locked <= w_owner_lock;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
